// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared types and default widths for the sequential restoring divider.
//   Contents:
//     div_state_e     FSM state encoding {IDLE, CALC, DONE}
//     DIV_DIVIDEND_W  default dividend/quotient width
//     DIV_DIVISOR_W   default divisor/remainder width
//     DIV_CNT_W       step-counter width at the default dividend width
//     cnt_width()     step-counter width for an arbitrary dividend width
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_DIVIDEND_W = 8;
  localparam int DIV_DIVISOR_W  = 4;
  localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // The counter holds DIVIDEND_W-1 down to 0; keep at least one bit so a
  // degenerate 1-bit dividend still elaborates.
  function automatic int cnt_width(input int dividend_w);
    return (dividend_w > 1) ? $clog2(dividend_w) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_if
//   Operand and result handshakes of the sequential restoring divider.
//   Signals:
//     in_valid / in_ready     operand pair handshake
//     dividend, divisor       unsigned operands
//     out_valid / out_ready   result handshake
//     quotient, remainder     unsigned results
//     div_by_zero             result came from divisor == 0
//   Modports:
//     master  operand producer / result consumer
//     slave   the divider itself
// -----------------------------------------------------------------------------
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/FullAdder.sv
// -----------------------------------------------------------------------------
// FullAdder
//   Single-bit full adder cell shared across the arithmetic datapath.
//   Ports:
//     a, b   addend bits
//     cin    carry in
//     s      sum
//     cout   carry out
// -----------------------------------------------------------------------------
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step: shift the next dividend bit
//   into the partial remainder, trial-subtract the divisor, keep the
//   difference if it did not go negative.
//   Ports:
//     r_in     partial remainder from the previous step (always < divisor)
//     bit_in   next dividend bit, MSB first
//     divisor  unsigned divisor
//     r_out    partial remainder after this step
//     q_bit    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 q_bit
);

  localparam int W = DIVISOR_W + 1;

  logic [W-1:0] shifted;
  logic [W-1:0] sub_b;
  logic [W-1:0] diff;
  logic [W:0]   carry;
  logic         diff_msb_unused;

  // The shifted value needs one extra bit: r_in < divisor, so {r_in, bit}
  // can reach 2*divisor-1.
  assign shifted  = {r_in, bit_in};
  assign sub_b    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  // shifted - divisor as shifted + ~divisor + 1; the final carry is the
  // "no borrow" flag, i.e. shifted >= divisor.
  for (genvar i = 0; i < W; i++) begin : g_fa
    FullAdder u_fa (
      .a   (shifted[i]),
      .b   (sub_b[i]),
      .cin (carry[i]),
      .s   (diff[i]),
      .cout(carry[i+1])
    );
  end

  assign q_bit = carry[W];

  // A kept difference is < divisor, so its top bit is always zero.
  assign r_out           = q_bit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
  assign diff_msb_unused = diff[W-1];

endmodule

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned sequential restoring divider, one quotient bit per clock,
//   valid/ready handshakes on operand and result sides.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset; aborts any operation in flight
//     bus   seq_restoring_divider_if.slave (operands in, results out)
//   Build option:
//     DIV_ZERO_SHORTCUT_EN  when defined, a zero divisor skips CALC and the
//                           result is presented one cycle after accept.
//                           Result values are the same in both builds.
// -----------------------------------------------------------------------------
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_restoring_divider_if.slave bus
);

  localparam int                CNT_W    = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;     // dividend, shifted left each step
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;     // running partial remainder
  logic [DIVIDEND_W-1:0] quo_q, quo_d;     // quotient bits collected so far
  logic                  zero_q, zero_d;   // divisor was zero at accept
  logic [DIVIDEND_W-1:0] quo_out_q, quo_out_d;
  logic [DIVISOR_W-1:0]  rem_out_q, rem_out_d;
  logic                  dz_out_q, dz_out_d;

  logic [DIVISOR_W-1:0]  step_r;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] quo_next;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r_in   (rem_q),
    .bit_in (dvd_q[DIVIDEND_W-1]),
    .divisor(dsr_q),
    .r_out  (step_r),
    .q_bit  (step_q)
  );

  assign quo_next = (quo_q << 1) | DIVIDEND_W'(step_q);

  // Gated by rst so nothing is accepted while reset is asserted.
  assign bus.in_ready    = (state_q == IDLE) && !rst;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dz_out_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    zero_d    = zero_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dz_out_d  = dz_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dvd_d   = bus.dividend;
          dsr_d   = bus.divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_LAST;
          zero_d  = (bus.divisor == '0);
`ifdef DIV_ZERO_SHORTCUT_EN
          if (bus.divisor == '0) begin
            quo_out_d = '1;
            rem_out_d = bus.dividend[DIVISOR_W-1:0];
            dz_out_d  = 1'b1;
            state_d   = DONE;
          end else begin
            state_d   = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end

      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = step_r;
        quo_d = quo_next;
        if (cnt_q == '0) begin
          // With a zero divisor every step subtracts nothing, so the
          // remainder already ends as the dividend's low bits; only the
          // quotient needs pinning to all ones.
          quo_out_d = zero_q ? '1 : quo_next;
          rem_out_d = step_r;
          dz_out_d  = zero_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs: reset clears them and drops any result.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dz_out_q  <= dz_out_d;
    end
  end

  // NOTE: working registers carry no reset; they are always reloaded at
  // accept before being read, so resetting them would only cost routing.
  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    dvd_q  <= dvd_d;
    dsr_q  <= dsr_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    zero_q <= zero_d;
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Self-checking bench for seq_restoring_divider: directed cases, back-
//   pressure, reset mid-operation and a full sweep of 8-bit x 4-bit operands
//   with random out_ready. Expected results are queued when an operand pair is
//   offered and popped when the result appears.
//   Honours DIV_ZERO_SHORTCUT_EN for the divide-by-zero latency.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int LAT_NORMAL = 9;
`ifdef DIV_ZERO_SHORTCUT_EN
  localparam int LAT_DZ = 1;
`else
  localparam int LAT_DZ = 9;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int asserts = 0;
  int fails   = 0;

  exp_t sb[$];

  seq_restoring_divider_if bus ();

  seq_restoring_divider dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] q, input logic [3:0] r, input logic dz);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b);
    if (b == 4'd0) return mk(8'hFF, a[3:0], 1'b1);
    return mk(8'(a / b), 4'(a % b), 1'b0);
  endfunction

  // Offer a/b, wait for the result, compare with the queued expectation,
  // optionally hold out_ready low for hold_n cycles, then drain.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, input exp_t e,
                         input int exp_lat, input int hold_n, input bit rnd,
                         input bit arith);
    int   lat;
    int   tries;
    bit   rdy;
    exp_t got_exp;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    sb.push_back(e);
    check("in_ready_offer", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the operand ports: they must be ignored once accepted.
    bus.in_valid = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~b;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got_exp = sb.pop_front();
      check("quotient", 32'(bus.quotient), 32'(got_exp.q));
      check("remainder", 32'(bus.remainder), 32'(got_exp.r));
      check("div_by_zero", 32'(bus.div_by_zero), 32'(got_exp.dz));
    end
    if (arith && b != 4'd0) begin
      check("q_times_d_plus_r", 32'(int'(bus.quotient) * int'(b) + int'(bus.remainder)), 32'(a));
      check("rem_lt_div", 32'(bus.remainder < b), 32'd1);
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold_n; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_quotient", 32'(bus.quotient), 32'(e.q));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    tries = 0;
    do begin
      rdy = (rnd && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      tries++;
    end while (!rdy);
    bus.out_ready = 1'b0;
    check("out_valid_after_drain", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_drain", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bit ov_seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Directed cases.
    run_div(8'd36,  4'd9,  mk(8'd4,   4'd0, 1'b0), LAT_NORMAL, 0, 1'b0, 1'b0);
    run_div(8'd200, 4'd7,  mk(8'd28,  4'd4, 1'b0), LAT_NORMAL, 0, 1'b0, 1'b0);
    run_div(8'd255, 4'd15, mk(8'd17,  4'd0, 1'b0), LAT_NORMAL, 0, 1'b0, 1'b0);
    run_div(8'd3,   4'd12, mk(8'd0,   4'd3, 1'b0), LAT_NORMAL, 0, 1'b0, 1'b0);
    run_div(8'd100, 4'd0,  mk(8'd255, 4'd4, 1'b1), LAT_DZ,     0, 1'b0, 1'b0);

    // Backpressure: result held for 5 cycles with out_ready low.
    run_div(8'd12,  4'd4,  mk(8'd3,   4'd0, 1'b0), LAT_NORMAL, 5, 1'b0, 1'b0);

    // Reset pulsed in cycle 4 of 200 / 7.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    check("abort_in_ready_offer", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ov_seen = bus.out_valid;
    repeat (3) begin
      @(negedge clk);
      ov_seen |= bus.out_valid;
    end
    rst = 1'b1;
    #1;
    check("abort_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_div_by_zero", 32'(bus.div_by_zero), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (12) begin
      @(negedge clk);
      ov_seen |= bus.out_valid;
    end
    check("abort_never_valid", 32'(ov_seen), 32'd0);
    run_div(8'd36, 4'd9, mk(8'd4, 4'd0, 1'b0), LAT_NORMAL, 0, 1'b0, 1'b0);

    // Full operand sweep with random out_ready.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(8'(a), 4'(b), model(8'(a), 4'(b)),
                (b == 0) ? LAT_DZ : LAT_NORMAL, 0, 1'b1, 1'b1);
      end
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
